// File: rtl/trenc_pkg.sv
// Shared widths, register offsets and access-FSM states for the trace-encoder filter configuration block.
package trenc_pkg;

    localparam int unsigned APBDWIDTH = 32;
    localparam int unsigned APBAWIDTH = 12;
    localparam int unsigned FILTER_W  = 10;

    localparam logic [APBAWIDTH-1:0] OFF_FILTER    = 12'h000;
    localparam logic [APBAWIDTH-1:0] OFF_FILADDR0H = 12'h004;
    localparam logic [APBAWIDTH-1:0] OFF_FILADDR0L = 12'h008;
    localparam logic [APBAWIDTH-1:0] OFF_FILADDR1H = 12'h00C;
    localparam logic [APBAWIDTH-1:0] OFF_FILADDR1L = 12'h010;
    localparam logic [APBAWIDTH-1:0] OFF_CTRL      = 12'h014;
    localparam logic [APBAWIDTH-1:0] OFF_STATUS    = 12'h018;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/trenc_filter_cfg_if.sv
// APB3 slave bundle for the filter configuration registers.
interface trenc_filter_cfg_if;
    import trenc_pkg::*;

    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [APBAWIDTH-1:0] paddr;
    logic [APBDWIDTH-1:0] pwdata;
    logic [APBDWIDTH-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/trenc_filter_cfg.sv
// APB register block configuring the trace-encoder filter: control, address ranges,
// enable/start and the sticky qualified-first status. One wait state per transfer.
module trenc_filter_cfg
    import trenc_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  trenc_clk_i,
    input  logic                  trenc_rst_i,
    trenc_filter_cfg_if.slave     apb,
    output logic [APBDWIDTH-1:0]  trenc_filter_o,
    output logic [APBDWIDTH-1:0]  trenc_filaddr0h_o,
    output logic [APBDWIDTH-1:0]  trenc_filaddr0l_o,
    output logic [APBDWIDTH-1:0]  trenc_filaddr1h_o,
    output logic [APBDWIDTH-1:0]  trenc_filaddr1l_o,
    output logic                  trenc_enable_o,
    output logic                  trenc_start_o,
    input  logic                  trenc_qualified_first_i
);

    state_e               state_q;
    logic [APBAWIDTH-1:0] addr_q;
    logic [APBDWIDTH-1:0] wdata_q;
    logic                 write_q;
    logic [APBDWIDTH-1:0] prdata_q;
    logic                 pslverr_q;

    logic [FILTER_W-1:0]  filter_q;
    logic [APBDWIDTH-1:0] fa0h_q, fa0l_q, fa1h_q, fa1l_q;
    logic                 enable_q;
    logic                 start_q;
    logic                 qf_q;

    logic                 err_c;
    logic [APBDWIDTH-1:0] rdata_c;
    logic                 commit_c;
    logic                 qf_clr_c;

    // Decode of the address presented at the sampling edge; lock uses ENABLE before this write.
    always_comb begin
        err_c   = 1'b0;
        rdata_c = '0;
        if ((apb.paddr[1:0] != 2'b00) || (apb.paddr > OFF_STATUS)) begin
            err_c = 1'b1;
        end else if (LOCK_EN && enable_q && apb.pwrite && (apb.paddr <= OFF_FILADDR1L)) begin
            err_c = 1'b1;
        end
        case (apb.paddr)
            OFF_FILTER:    rdata_c = APBDWIDTH'(filter_q);
            OFF_FILADDR0H: rdata_c = fa0h_q;
            OFF_FILADDR0L: rdata_c = fa0l_q;
            OFF_FILADDR1H: rdata_c = fa1h_q;
            OFF_FILADDR1L: rdata_c = fa1l_q;
            OFF_STATUS:    rdata_c = APBDWIDTH'({qf_q, enable_q});
            default:       rdata_c = '0;
        endcase
    end

    // A write lands only if the access is still held through the response cycle.
    assign commit_c = (state_q == ST_RESP) && apb.psel && apb.penable && write_q && !pslverr_q;
    assign qf_clr_c = commit_c && (addr_q == OFF_STATUS) && wdata_q[1];

    always_ff @(posedge trenc_clk_i) begin
        if (trenc_rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            filter_q  <= '0;
            fa0h_q    <= '0;
            fa0l_q    <= '0;
            fa1h_q    <= '0;
            fa1l_q    <= '0;
            enable_q  <= 1'b0;
            start_q   <= 1'b0;
            qf_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            qf_q    <= (qf_q & ~qf_clr_c) | trenc_qualified_first_i;
            case (state_q)
                ST_IDLE: begin
                    if (apb.psel && apb.penable) begin
                        state_q   <= ST_RESP;
                        addr_q    <= apb.paddr;
                        wdata_q   <= apb.pwdata;
                        write_q   <= apb.pwrite;
                        pslverr_q <= err_c;
                        prdata_q  <= (apb.pwrite || err_c) ? '0 : rdata_c;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    if (commit_c) begin
                        case (addr_q)
                            OFF_FILTER:    filter_q <= wdata_q[FILTER_W-1:0];
                            OFF_FILADDR0H: fa0h_q   <= wdata_q;
                            OFF_FILADDR0L: fa0l_q   <= wdata_q;
                            OFF_FILADDR1H: fa1h_q   <= wdata_q;
                            OFF_FILADDR1L: fa1l_q   <= wdata_q;
                            OFF_CTRL: begin
                                enable_q <= wdata_q[0];
                                start_q  <= wdata_q[0] & wdata_q[1];
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign apb.prdata        = prdata_q;
    assign apb.pslverr       = pslverr_q;
    assign apb.pready        = (state_q == ST_RESP);
    assign trenc_filter_o    = APBDWIDTH'(filter_q);
    assign trenc_filaddr0h_o = fa0h_q;
    assign trenc_filaddr0l_o = fa0l_q;
    assign trenc_filaddr1h_o = fa1h_q;
    assign trenc_filaddr1l_o = fa1l_q;
    assign trenc_enable_o    = enable_q;
    assign trenc_start_o     = start_q;

endmodule

// File: tb/tb_trenc_filter_cfg.sv
// Scoreboard bench for trenc_filter_cfg: directed register scenarios plus random APB traffic
// checked against a register-level model of the block.
module tb_trenc_filter_cfg;
    import trenc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trenc_filter_cfg_if apb();

    logic [31:0] filter_o, fa0h_o, fa0l_o, fa1h_o, fa1l_o;
    logic        enable_o, start_o, qfi;

    trenc_filter_cfg #(.LOCK_EN(1'b1)) dut (
        .trenc_clk_i             (clk),
        .trenc_rst_i             (rst),
        .apb                     (apb),
        .trenc_filter_o          (filter_o),
        .trenc_filaddr0h_o       (fa0h_o),
        .trenc_filaddr0l_o       (fa0l_o),
        .trenc_filaddr1h_o       (fa1h_o),
        .trenc_filaddr1l_o       (fa1l_o),
        .trenc_enable_o          (enable_o),
        .trenc_start_o           (start_o),
        .trenc_qualified_first_i (qfi)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Reference model: the programmer-visible register file.
    logic [9:0]  m_filter;
    logic [31:0] m_fa [4];
    logic        m_en, m_qf;
    int          start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h000: return {22'd0, m_filter};
            12'h004: return m_fa[0];
            12'h008: return m_fa[1];
            12'h00C: return m_fa[2];
            12'h010: return m_fa[3];
            12'h018: return {30'd0, m_qf, m_en};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_err(input bit wr, input logic [11:0] a);
        if (a % 4 != 0 || a > 12'h018) return 1'b1;
        return wr && m_en && (a <= 12'h010);
    endfunction

    task automatic m_reset();
        m_filter = '0;
        for (int i = 0; i < 4; i++) m_fa[i] = '0;
        m_en = 1'b0;
        m_qf = 1'b0;
    endtask

    task automatic check_outputs();
        check("filter_o",   filter_o, {22'd0, m_filter});
        check("filaddr0h",  fa0h_o,   m_fa[0]);
        check("filaddr0l",  fa0l_o,   m_fa[1]);
        check("filaddr1h",  fa1h_o,   m_fa[2]);
        check("filaddr1l",  fa1l_o,   m_fa[3]);
        check("enable_o",   32'(enable_o), 32'(m_en));
    endtask

    // Monitor: every pready cycle consumes one expected response.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (apb.pready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pready: got pready=1 expected no transfer");
            end else begin
                mon_e = sbq.pop_front();
                if (apb.prdata !== mon_e.rd || apb.pslverr !== mon_e.err) begin
                    errors++;
                    $display("FAIL apb_resp: got prdata=0x%08h pslverr=%0b expected prdata=0x%08h pslverr=%0b",
                             apb.prdata, apb.pslverr, mon_e.rd, mon_e.err);
                end
            end
        end else if (!rst && apb.prdata !== 32'd0) begin
            checks++;
            errors++;
            $display("FAIL prdata_idle: got 0x%08h expected 0x00000000", apb.prdata);
        end
    end

    // One APB transfer; abort drops penable in the response cycle, qf_pulse raises
    // qualified_first in the response cycle so it coincides with the commit edge.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input bit qf_pulse, input bit abort);
        exp_t e;
        bit   err, exp_start;
        int   s0, n;
        err  = m_err(wr, a);
        e.err = err;
        e.rd  = (wr || err) ? 32'd0 : m_read(a);
        sbq.push_back(e);
        s0 = start_cnt;
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        n = 0;
        while (!apb.pready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("pready_latency", 32'(n), 32'd0);
        if (qf_pulse) qfi = 1'b1;
        if (abort) apb.penable = 1'b0;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; qfi = 1'b0;
        exp_start = 1'b0;
        if (wr && !err && !abort) begin
            case (a)
                12'h000: m_filter = d[9:0];
                12'h004: m_fa[0] = d;
                12'h008: m_fa[1] = d;
                12'h00C: m_fa[2] = d;
                12'h010: m_fa[3] = d;
                12'h014: begin m_en = d[0]; exp_start = d[0] & d[1]; end
                12'h018: if (d[1]) m_qf = 1'b0;
                default: ;
            endcase
        end
        if (qf_pulse) m_qf = 1'b1;
        repeat (2) @(negedge clk);
        check("start_pulses", 32'(start_cnt - s0), 32'(exp_start));
        check_outputs();
    endtask

    task automatic qf_idle_pulse();
        @(negedge clk); qfi = 1'b1;
        @(negedge clk); qfi = 1'b0;
        m_qf = 1'b1;
    endtask

    initial begin
        int s0;
        logic [11:0] a;
        logic [31:0] d;
        int sel;
        rst = 1'b1; qfi = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_pready",  32'(apb.pready),  32'd0);
        check("rst_pslverr", 32'(apb.pslverr), 32'd0);
        check("rst_prdata",  apb.prdata,       32'd0);
        check("rst_start",   32'(start_o),     32'd0);
        check_outputs();
        rst = 1'b0;

        // Filter write/read and reserved bits.
        xfer(1, 12'h000, 32'h0000_03A5, 0, 0);
        xfer(0, 12'h000, 32'h0, 0, 0);
        xfer(1, 12'h000, 32'hFFFF_FC5A, 0, 0);
        xfer(0, 12'h000, 32'h0, 0, 0);
        // Enable with start, then start without enable.
        xfer(1, 12'h014, 32'h3, 0, 0);
        xfer(0, 12'h014, 32'h0, 0, 0);
        xfer(1, 12'h014, 32'h2, 0, 0);
        // Lock while enabled, unlock after ENABLE cleared.
        xfer(1, 12'h014, 32'h1, 0, 0);
        xfer(1, 12'h004, 32'hDEAD_BEEF, 0, 0);
        xfer(0, 12'h004, 32'h0, 0, 0);
        xfer(0, 12'h018, 32'h0, 0, 0);
        xfer(1, 12'h014, 32'h0, 0, 0);
        xfer(1, 12'h004, 32'hDEAD_BEEF, 0, 0);
        xfer(0, 12'h004, 32'h0, 0, 0);
        // Unmapped and misaligned.
        xfer(0, 12'h020, 32'h0, 0, 0);
        xfer(0, 12'h005, 32'h0, 0, 0);
        xfer(1, 12'h00A, 32'h1234_5678, 0, 0);
        // Sticky QF with set-over-clear.
        qf_idle_pulse();
        xfer(0, 12'h018, 32'h0, 0, 0);
        xfer(1, 12'h018, 32'h2, 1, 0);
        xfer(0, 12'h018, 32'h0, 0, 0);
        xfer(1, 12'h018, 32'h2, 0, 0);
        xfer(0, 12'h018, 32'h0, 0, 0);
        // Aborted write leaves registers untouched.
        xfer(1, 12'h008, 32'hCAFE_F00D, 0, 1);
        xfer(0, 12'h008, 32'h0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 12'(sel * 4);
            else if (sel == 7) a = 12'($urandom_range(0, 4095));
            else               a = 12'h014;
            d = $urandom;
            if ($urandom_range(0, 5) == 0) qf_idle_pulse();
            xfer(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        // Reset landing in the response cycle of an enabling CTRL write.
        xfer(1, 12'h014, 32'h0, 0, 0);
        sbq.push_back('{rd: 32'd0, err: 1'b0});
        s0 = start_cnt;
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 12'h014; apb.pwdata = 32'h1;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        check("rstresp_pready_in", 32'(apb.pready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
        m_reset();
        check("rstresp_pready", 32'(apb.pready), 32'd0);
        check("rstresp_start",  32'(start_o),    32'd0);
        repeat (2) @(negedge clk);
        check("rstresp_pulses", 32'(start_cnt - s0), 32'd0);
        check_outputs();
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
